regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single register-file write port (A3/WD3/WE3) among several writeback requesters with round-robin fairness, and clears every register after reset before any writeback is admitted. It sits between the writeback sources (ALU result, load unit, CSR/misc) and the 32-entry register file. The write command is registered, so the register file sees one clean write per cycle.

## Interface
- ADDR_WIDTH, 5, register address width
- DATA_WIDTH, 32, register data width
- NUM_REQ, 3, number of writeback requesters (≥2)

Ports:
- CLK  in  1  sole clock, rising edge
- RST  in  1  reset: synchronous and active-high
- REQ_VALID  in  NUM_REQ  requester i has a write pending
- REQ_ADDR  in  NUM_REQ*ADDR_WIDTH  destination of requester i, slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  write data of requester i, slice [i*DATA_WIDTH +: DATA_WIDTH]
- REQ_READY  out  NUM_REQ  one-hot grant; a transfer occurs on a rising edge where VALID[i] and READY[i] are both high
- A3  out  ADDR_WIDTH  register-file write address, registered
- WD3  out  DATA_WIDTH  register-file write data, registered
- WE3  out  1  register-file write enable, registered
- BUSY  out  1  high while the clear sequence runs

## Operation
- State machine with 2 states, INIT and RUN. RST forces INIT.
- INIT:
  - Counter `clr_cnt` (ADDR_WIDTH bits) issues one write per cycle: A3=clr_cnt, WD3=0, WE3=1, for addresses 0 through 2**ADDR_WIDTH-1 in order.
  - When address 2**ADDR_WIDTH-1 is issued, the state moves to RUN.
  - REQ_READY stays all-zero.
- RUN, arbitration:
  - Round-robin over REQ_VALID. The priority pointer `ptr` names the highest-priority requester, and the search order is ptr, ptr+1, … modulo NUM_REQ.
  - At most one REQ_READY bit is high. It is combinational from REQ_VALID and `ptr`, and is never high for a non-valid requester.
- RUN, on a transfer from requester g:
  - The next edge loads A3=REQ_ADDR[g], WD3=REQ_DATA[g], WE3=1.
  - `ptr` becomes (g+1) mod NUM_REQ.
- RUN, with no valid requester: WE3=0 next cycle, A3/WD3 hold, `ptr` holds.
- Requesters must hold VALID/ADDR/DATA stable until READY. A requester that is not granted is not dropped, and with NUM_REQ requesters it is served within NUM_REQ grants.
- Address 0 writes are forwarded unchanged unless configured otherwise (see Configuration).
- `ptr` updates modulo NUM_REQ, so non-power-of-two NUM_REQ must wrap correctly. `clr_cnt` wraps naturally at 2**ADDR_WIDTH; its wrap is the exit condition.

## Timing
- While RST is high: A3=0, WD3=0, WE3=0, REQ_READY=0, BUSY=1, `ptr`=0, `clr_cnt`=0, state INIT.
- Edge E0 is the first edge with RST low; it presents the first clear write (A3=0, WE3=1). WE3 then stays high for 2**ADDR_WIDTH consecutive cycles, with A3 = 0,1,…,31.
- BUSY is combinational from state. It drops in the cycle A3=31 is presented.
- REQ_READY may first assert in the cycle A3=31 is presented, so there is no bubble between clear and the first writeback.
- Grant-to-port latency: a transfer at edge N appears on A3/WD3/WE3 from edge N to N+1. The register file commits it at edge N+1, so writeback-to-readable is 2 edges.
- Sustained throughput is one write per cycle; back-to-back grants to different requesters give WE3 continuously high.
- RST asserted mid-operation: at that edge the outputs take their reset values and any in-flight registered write is discarded (WE3=0). The clear sequence restarts from address 0 once RST falls.
- RST asserted mid-clear has the same result: full restart at address 0.

## Configuration
- Macro: `RFARB_X0_DROP_EN`.
- Defined: a granted request with address 0 completes its handshake normally and advances `ptr`, but the registered WE3 for that beat is 0; A3/WD3 still load. The clear write to address 0 in INIT is also suppressed (WE3=0 in that cycle only).
- Undefined: address-0 writes reach the register file unchanged, and the file itself keeps x0 at zero.

## Structure
- Package `rf_arb_pkg`:
  - state enum `rf_arb_state_t` {INIT, RUN}
  - default width constants RF_ADDR_WIDTH=5 and RF_DATA_WIDTH=32
- Sub-module `rr_arbiter`, parameter NUM_REQ:
  - inputs: request vector, pointer
  - outputs: one-hot grant and encoded grant index; purely combinational
- The pointer register lives in `regfile_write_arbiter`.

## Test plan
- Reset then release, no requests:
  - 32 consecutive WE3 cycles with A3=0..31 and WD3=0.
  - BUSY low from the A3=31 cycle onward.
  - Register file then reads 0 everywhere.
- All three VALID held high in RUN, `ptr`=0: grants in order 0,1,2,0,1,2, and WE3 continuously high.
- Requester 1 only, writing 0xDEADBEEF to x5: READY[1] is high the same cycle, and A3=5/WD3=0xDEADBEEF/WE3=1 appears next cycle.
- RST pulsed for one cycle while requester 2 is granted: WE3=0 the following cycle, and the clear restarts at A3=0 with REQ_READY all zero for 31 cycles.
- REQ_VALID held high during INIT: no READY until the A3=31 cycle.
- With `RFARB_X0_DROP_EN` defined, requester 0 writes 0x1234 to x0:
  - handshake completes and `ptr` advances to 1;
  - WE3 stays 0 in the beat after the grant;
  - the INIT clear shows WE3=0 only at A3=0.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and default widths for the register-file write arbiter.
// Pure declarations; no logic, no latency.
package rf_arb_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_arb_state_t;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;

  // Single conditional subtract is enough: operands are always below 2*n.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after i_ptr, wrapping modulo NUM_REQ.
// Purely combinational, zero latency; no grant when no request is set.
module rr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [$clog2(NUM_REQ)-1:0] o_gnt_idx
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = rr_wrap(int'(i_ptr) + k, NUM_REQ);
      if (!w_found && i_req[PTR_W'(w_idx)]) begin
        w_found                  = 1'b1;
        o_gnt[PTR_W'(w_idx)]     = 1'b1;
        o_gnt_idx                = PTR_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Clears all registers after reset, then round-robin shares the A3/WD3/WE3 write port.
// Write command registered (1 cycle grant-to-port); losers hold VALID until READY.
// Optional RFARB_X0_DROP_EN: suppress WE3 for every address-0 write, including the clear.
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_REQ    = 3
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic [ADDR_WIDTH-1:0]         A3,
  output logic [DATA_WIDTH-1:0]         WD3,
  output logic                          WE3,
  output logic                          BUSY
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  rf_arb_state_t          r_state;
  logic [ADDR_WIDTH-1:0]  r_clr_cnt;
  logic [PTR_W-1:0]       r_ptr;

  logic [NUM_REQ-1:0]     w_req;
  logic [NUM_REQ-1:0]     w_gnt;
  logic [PTR_W-1:0]       w_gnt_idx;
  logic                   w_gnt_any;
  logic [PTR_W-1:0]       w_ptr_nxt;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic                   w_clr_last;
  logic                   w_clr_we;
  logic                   w_run_we;

  // Requests are invisible until the clear has issued its last address.
  assign w_req = (r_state == RUN) ? REQ_VALID : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req     (w_req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign REQ_READY  = w_gnt;
  assign BUSY       = (r_state == INIT);
  assign w_gnt_any  = |w_gnt;
  assign w_ptr_nxt  = (w_gnt_idx == LAST_REQ) ? '0 : w_gnt_idx + 1'b1;
  assign w_clr_last = (r_clr_cnt == '1);

  // AND-OR mux on the one-hot grant.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef RFARB_X0_DROP_EN
  assign w_clr_we = (r_clr_cnt != '0);
  assign w_run_we = (w_sel_addr != '0);
`else
  assign w_clr_we = 1'b1;
  assign w_run_we = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= INIT;
      r_clr_cnt <= '0;
      r_ptr     <= '0;
      A3        <= '0;
      WD3       <= '0;
      WE3       <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          A3        <= r_clr_cnt;
          WD3       <= '0;
          WE3       <= w_clr_we;
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (w_clr_last) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_gnt_any) begin
            A3    <= w_sel_addr;
            WD3   <= w_sel_data;
            WE3   <= w_run_we;
            r_ptr <= w_ptr_nxt;
          end else begin
            WE3 <= 1'b0;
          end
        end
        default: begin
          r_state <= INIT;
          WE3     <= 1'b0;
        end
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(REQ_READY));
  a_ready_valid:  assert property (@(posedge CLK) disable iff (RST) (REQ_READY & ~REQ_VALID) == '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed spot checks plus randomized traffic against a behavioural model.
module tb_regfile_write_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int N    = 3;
  localparam int NREG = 32;
`ifdef RFARB_X0_DROP_EN
  localparam bit X0DROP = 1'b1;
`else
  localparam bit X0DROP = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    REQ_VALID;
  logic [N*AW-1:0] REQ_ADDR;
  logic [N*DW-1:0] REQ_DATA;
  logic [N-1:0]    REQ_READY;
  logic [AW-1:0]   A3;
  logic [DW-1:0]   WD3;
  logic            WE3;
  logic            BUSY;

  regfile_write_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REQ    (N)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_DATA  (REQ_DATA),
    .REQ_READY (REQ_READY),
    .A3        (A3),
    .WD3       (WD3),
    .WE3       (WE3),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: clear phase counted in cycles since reset release, then plain round-robin.
  int            m_cyc = 0;
  int            m_ptr = 0;
  logic [AW-1:0] m_a3  = '0;
  logic [DW-1:0] m_wd  = '0;
  logic          m_we  = 1'b0;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int i = (p + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge CLK) begin : model
    int g;
    if (RST) begin
      m_cyc = 0; m_ptr = 0; m_a3 = '0; m_wd = '0; m_we = 1'b0;
    end else if (m_cyc < NREG) begin
      m_a3 = AW'(m_cyc);
      m_wd = '0;
      m_we = !(X0DROP && m_cyc == 0);
      m_cyc++;
    end else begin
      g = pick(REQ_VALID, m_ptr);
      if (g >= 0) begin
        m_a3  = REQ_ADDR[g*AW +: AW];
        m_wd  = REQ_DATA[g*DW +: DW];
        m_we  = !(X0DROP && REQ_ADDR[g*AW +: AW] == '0);
        m_ptr = (g + 1) % N;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin : compare
    int g;
    logic [N-1:0] er;
    if (chk_en) begin
      g  = (m_cyc >= NREG) ? pick(REQ_VALID, m_ptr) : -1;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("m_ready", REQ_READY, er);
      chk("m_busy", BUSY, m_cyc < NREG);
      chk("m_we3", WE3, m_we);
      chk("m_a3", A3, m_a3);
      chk("m_wd3", WD3, m_wd);
    end
  end

  logic [DW-1:0] rf [NREG];
  always @(posedge CLK) if (WE3 === 1'b1) rf[A3] <= WD3;

  task automatic nxt();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive_edge();
    @(posedge CLK);
    #1;
  endtask

  logic [N-1:0]  ord   [6];
  logic [AW-1:0] ord_a [6];
  logic [N-1:0]  rdy_s;

  initial begin
    for (int r = 0; r < NREG; r++) rf[r] = 32'hA5A5_A5A5;
    RST = 1'b1; REQ_VALID = '0; REQ_ADDR = '0; REQ_DATA = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_en = 1'b1;
    chk("rst_a3", A3, 0);
    chk("rst_wd3", WD3, 0);
    chk("rst_we3", WE3, 0);
    chk("rst_busy", BUSY, 1);
    chk("rst_ready", REQ_READY, 0);

    // Clear sequence with no requesters.
    drive_edge(); RST = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      nxt();
      chk("clr_a3", A3, i);
      chk("clr_wd3", WD3, 0);
      chk("clr_we3", WE3, (X0DROP && i == 0) ? 0 : 1);
      chk("clr_busy", BUSY, (i == NREG - 1) ? 0 : 1);
    end
    nxt();
    chk("idle_we3", WE3, 0);
    chk("idle_a3_hold", A3, 31);
    for (int r = (X0DROP ? 1 : 0); r < NREG; r++) chk("rf_cleared", rf[r], 0);

    // All three requesters continuously valid from ptr=0.
    ord   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    ord_a = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    drive_edge();
    REQ_VALID = 3'b111;
    REQ_ADDR  = {5'd3, 5'd2, 5'd1};
    REQ_DATA  = {32'd300, 32'd200, 32'd100};
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("rr_ready", REQ_READY, ord[k]);
      if (k > 0) begin
        chk("rr_we3", WE3, 1);
        chk("rr_a3", A3, ord_a[k-1]);
      end
    end
    drive_edge(); REQ_VALID = '0;
    @(negedge CLK);
    chk("rr_last_a3", A3, 3);
    chk("rr_last_wd3", WD3, 300);

    // Single requester 1 writes x5.
    drive_edge();
    REQ_VALID = 3'b010; REQ_ADDR[AW +: AW] = 5'd5; REQ_DATA[DW +: DW] = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("r1_ready", REQ_READY, 3'b010);
    drive_edge(); REQ_VALID = '0;
    @(negedge CLK);
    chk("r1_a3", A3, 5);
    chk("r1_wd3", WD3, 32'hDEAD_BEEF);
    chk("r1_we3", WE3, 1);

    // Requester 0 writes x0; pointer must move on to requester 1.
    drive_edge();
    REQ_VALID = 3'b001; REQ_ADDR[0 +: AW] = 5'd0; REQ_DATA[0 +: DW] = 32'h1234;
    @(negedge CLK);
    chk("x0_ready", REQ_READY, 3'b001);
    drive_edge();
    REQ_VALID = 3'b111; REQ_ADDR[AW +: AW] = 5'd7; REQ_ADDR[2*AW +: AW] = 5'd9;
    @(negedge CLK);
    chk("x0_we3", WE3, X0DROP ? 0 : 1);
    chk("x0_a3", A3, 0);
    chk("x0_wd3", WD3, 32'h1234);
    chk("x0_ptr_next", REQ_READY, 3'b010);

    // Reset pulse while requester 2 is granted; its valid stays high through the clear.
    drive_edge(); REQ_VALID = 3'b100; RST = 1'b1;
    @(negedge CLK);
    chk("pulse_ready", REQ_READY, 3'b100);
    chk("pulse_a3", A3, 7);
    drive_edge(); RST = 1'b0;
    @(negedge CLK);
    chk("pulse_we3", WE3, 0);
    chk("pulse_ready0", REQ_READY, 0);
    chk("pulse_busy", BUSY, 1);
    for (int i = 0; i < NREG; i++) begin
      nxt();
      chk("reclr_a3", A3, i);
      chk("reclr_we3", WE3, (X0DROP && i == 0) ? 0 : 1);
      chk("reclr_ready", REQ_READY, (i == NREG - 1) ? 3'b100 : 3'b000);
    end
    drive_edge(); REQ_VALID = '0;
    @(negedge CLK);
    chk("reclr_first_wb", A3, 9);
    chk("reclr_first_we", WE3, 1);

    // Random traffic honouring hold-until-ready, with rare resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      rdy_s = REQ_READY;
      drive_edge();
      RST = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        if (!REQ_VALID[i] || rdy_s[i]) begin
          REQ_VALID[i] = ($urandom_range(0, 2) != 0);
          REQ_ADDR[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom_range(0, 31));
          REQ_DATA[i*DW +: DW] = $urandom;
        end
      end
    end
    drive_edge(); RST = 1'b0; REQ_VALID = '0;
    repeat (4) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
